// File: rtl/alu_arb.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered per-port response slot (1-cycle latency).
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif

module alu_arb #(
    parameter int unsigned TAG_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [`ALU_OP_WIDTH-1:0] req0_op,
    input  logic [`CPU_WIDTH-1:0]    req0_src1,
    input  logic [`CPU_WIDTH-1:0]    req0_src2,
    input  logic [TAG_WIDTH-1:0]     req0_tag,
    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [`ALU_OP_WIDTH-1:0] req1_op,
    input  logic [`CPU_WIDTH-1:0]    req1_src1,
    input  logic [`CPU_WIDTH-1:0]    req1_src2,
    input  logic [TAG_WIDTH-1:0]     req1_tag,
    output logic [`ALU_OP_WIDTH-1:0] alu_op,
    output logic [`CPU_WIDTH-1:0]    alu_src1,
    output logic [`CPU_WIDTH-1:0]    alu_src2,
    input  logic [`CPU_WIDTH-1:0]    alu_res,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [`CPU_WIDTH-1:0]    rsp0_res,
    output logic [TAG_WIDTH-1:0]     rsp0_tag,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [`CPU_WIDTH-1:0]    rsp1_res,
    output logic [TAG_WIDTH-1:0]     rsp1_tag
);

    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_grant0;
    logic                  w_grant1;
    logic                  r_prio;
    logic                  r_rsp0_valid;
    logic [`CPU_WIDTH-1:0] r_rsp0_res;
    logic [TAG_WIDTH-1:0]  r_rsp0_tag;
    logic                  r_rsp1_valid;
    logic [`CPU_WIDTH-1:0] r_rsp1_res;
    logic [TAG_WIDTH-1:0]  r_rsp1_tag;

    // A slot may accept a new op when empty or being drained this cycle.
    always_comb begin
        w_elig0  = req0_valid && (!r_rsp0_valid || rsp0_ready) && !rst;
        w_elig1  = req1_valid && (!r_rsp1_valid || rsp1_ready) && !rst;
        w_grant0 = w_elig0 && (!w_elig1 || !r_prio);
        w_grant1 = w_elig1 && (!w_elig0 || r_prio);
    end

    always_comb begin
        alu_op   = '0;
        alu_src1 = '0;
        alu_src2 = '0;
        if (w_grant0) begin
            alu_op   = req0_op;
            alu_src1 = req0_src1;
            alu_src2 = req0_src2;
        end else if (w_grant1) begin
            alu_op   = req1_op;
            alu_src1 = req1_src1;
            alu_src2 = req1_src2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prio <= 1'b0;
        end else if (w_grant0) begin
            r_prio <= 1'b1;
        end else if (w_grant1) begin
            r_prio <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp0_res   <= '0;
            r_rsp0_tag   <= '0;
        end else if (w_grant0) begin
            r_rsp0_valid <= 1'b1;
            r_rsp0_res   <= alu_res;
            r_rsp0_tag   <= req0_tag;
        end else if (rsp0_ready) begin
            r_rsp0_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp1_valid <= 1'b0;
            r_rsp1_res   <= '0;
            r_rsp1_tag   <= '0;
        end else if (w_grant1) begin
            r_rsp1_valid <= 1'b1;
            r_rsp1_res   <= alu_res;
            r_rsp1_tag   <= req1_tag;
        end else if (rsp1_ready) begin
            r_rsp1_valid <= 1'b0;
        end
    end

    always_comb begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        rsp0_valid = r_rsp0_valid;
        rsp0_res   = r_rsp0_res;
        rsp0_tag   = r_rsp0_tag;
        rsp1_valid = r_rsp1_valid;
        rsp1_res   = r_rsp1_res;
        rsp1_tag   = r_rsp1_tag;
    end

endmodule

// File: doc/alu_arb.md
Name: alu_arb

Overview:
- Two-port arbiter that shares one combinational ALU instance between two requesters, e.g. the execute stage (port 0) and an address/branch helper (port 1).
- Accepts operation requests over valid/ready handshakes and arbitrates round-robin.
- Drives the shared ALU's alu_op/alu_src1/alu_src2 inputs and captures alu_res into a per-port registered response slot.
- Returns each result with its tag over a valid/ready response channel. Latency is 1 cycle.

Parameters:
- TAG_WIDTH, default 4: width of the request/response transaction tag.
- Data and opcode widths come from the global `CPU_WIDTH and `ALU_OP_WIDTH defines (not parameters).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- reqN_valid  input  1  request valid on port N (N=0,1).
- reqN_ready  output  1  request accepted this cycle.
- reqN_op  input  `ALU_OP_WIDTH  ALU opcode.
- reqN_src1  input  `CPU_WIDTH  operand 1.
- reqN_src2  input  `CPU_WIDTH  operand 2.
- reqN_tag  input  TAG_WIDTH  requester tag.
- alu_op  output  `ALU_OP_WIDTH  to the shared ALU.
- alu_src1  output  `CPU_WIDTH  to the shared ALU.
- alu_src2  output  `CPU_WIDTH  to the shared ALU.
- alu_res  input  `CPU_WIDTH  from the shared ALU (combinational).
- rspN_valid  output  1  response slot N holds a result.
- rspN_ready  input  1  consumer N takes the response.
- rspN_res  output  `CPU_WIDTH  registered result.
- rspN_tag  output  TAG_WIDTH  tag echoed from the request.

Behaviour:
- Reset (rst=1, asynchronous): rspN_valid=0, rspN_res=0, rspN_tag=0, prio=0. Pending responses are discarded on reset mid-operation. reqN_ready=0 while rst is high.
- Eligibility: port N is eligible when reqN_valid && (!rspN_valid || rspN_ready). The slot must be empty or draining in the same cycle.
- Grant (combinational):
  - Only one eligible port: that port is granted.
  - Both eligible: grant port prio.
  - Neither eligible: no grant.
- reqN_ready = grantN. reqN_ready may depend on reqN_valid; requesters must not depend on ready to raise valid.
- prio register: on any grant to port N, prio <= ~N next cycle. With no grant, prio holds. Under continuous dual requests, grants strictly alternate 0,1,0,1 starting at port 0 after reset.
- ALU drive:
  - When grantN, alu_op/src1/src2 = reqN_op/src1/src2.
  - With no grant, all are driven 0. The shared ALU's default case then yields 0; the result is ignored.
- Capture: on grantN at the clock edge, rspN_res <= alu_res, rspN_tag <= reqN_tag, rspN_valid <= 1. The result is visible the cycle after acceptance (1-cycle latency).
- Drain: rspN_valid && rspN_ready && !grantN -> rspN_valid <= 0. res/tag hold their last values.
- Simultaneous drain and new grant on the same port: the slot is overwritten with the new result and valid stays 1. The old response counts as consumed; no bubble.
- Backpressure: rspN_valid && !rspN_ready -> port N is ineligible. Its request stalls with reqN_ready=0 and its slot holds stable. The other port is unaffected and can still be granted every cycle.
- Ports are independent: the response slots never interact; only the ALU is shared.
- At most one grant per cycle. Throughput is 1 op/cycle total.
- No X propagation: outputs are fully defined after reset.

Test Plan:
- Single request: after reset, req0 with op=`ALU_ADD, src1=5, src2=7, tag=3, rsp0_ready=1 -> req0_ready=1 in cycle 0; rsp0_valid=1, rsp0_res=12, rsp0_tag=3 in cycle 1; rsp0_valid=0 in cycle 2.
- Contention:
  - Stimulus: both ports held valid for 4 cycles; port 0 `ALU_SUB 10-3, port 1 `ALU_XOR 0xF0^0xFF; both rsp ready.
  - Required: grant sequence 0,1,0,1; rsp0_res=7 and rsp1_res=0x0F each on alternate cycles.
- Backpressure:
  - Stimulus: rsp0_ready=0 with rsp0 slot full; req0 `ALU_SLL 1<<4 pending; req1 `ALU_OR 0x1|0x2 pending.
  - Required: req0_ready=0 and rsp0 holds its old value; port 1 is granted and rsp1_res=3.
  - Then raise rsp0_ready: req0 is granted next, and rsp0_res=16 follows one cycle later.
- Same-cycle drain and refill: rsp1_valid=1, rsp1_ready=1, req1 `ALU_SLT src1=0xFFFFFFFF src2=1 tag=9 valid -> req1_ready=1; next cycle rsp1_valid stays 1 with rsp1_res=1, rsp1_tag=9.
- Idle: no valids -> alu_op/src1/src2=0, prio unchanged, no rsp_valid asserted.
- Reset mid-operation: rsp0_valid=1, rsp1_valid=1, prio=1, assert rst asynchronously mid-cycle -> immediately all rsp*_valid/res/tag=0 and req*_ready=0; after deassert with dual requests, port 0 is granted first.
